// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand/result bundle for serial_adder.
// The SUB request line exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OVF;
`ifdef SERIAL_ADDER_SUB_EN
    logic             SUB;
    modport master(output START, A, B, Cin, SUB, input BUSY, DONE, S, Cout, OVF);
    modport slave(input START, A, B, Cin, SUB, output BUSY, DONE, S, Cout, OVF);
`else
    modport master(output START, A, B, Cin, input BUSY, DONE, S, Cout, OVF);
    modport slave(input START, A, B, Cin, output BUSY, DONE, S, Cout, OVF);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit bit-serial adder time-sharing one full-adder cell, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the SUB input (A-B-Cin with Cin as borrow-in).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           CLK,
    input logic           RST,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] b_in;
    logic             c_in, fa_s, fa_c, accept, last;

`ifdef SERIAL_ADDER_SUB_EN
    // subtraction is A + ~B + ~Cin, so Cout comes out as the inverted borrow
    assign b_in = bus.SUB ? ~bus.B : bus.B;
    assign c_in = bus.SUB ^ bus.Cin;
`else
    assign b_in = bus.B;
    assign c_in = bus.Cin;
`endif

    assign fa_s   = a_q[0] ^ b_q[0] ^ c_q;
    assign fa_c   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    assign accept = bus.START && state_q != RUN;
    assign last   = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            sum_d = {fa_s, sum_q[WIDTH-1:1]};
            c_d   = fa_c;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d = DONE;
                s_d     = {fa_s, sum_q[WIDTH-1:1]};
                cout_d  = fa_c;
                ovf_d   = c_q ^ fa_c;
            end
        end else if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = bus.A;
            b_d     = b_in;
            sum_d   = '0;
            c_d     = c_in;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.BUSY = state_q == RUN;
    assign bus.DONE = state_q == DONE;
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.OVF  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed stimulus on WIDTH=8 and WIDTH=2 adders,
// checked every cycle against an arithmetic result/latency model.
module tb_serial_adder;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    serial_adder_if #(.WIDTH(8)) b8();
    serial_adder_if #(.WIDTH(2)) b2();

    serial_adder #(.WIDTH(8)) u8 (.CLK(CLK), .RST(RST), .bus(b8));
    serial_adder #(.WIDTH(2)) u2 (.CLK(CLK), .RST(RST), .bus(b2));

    int checks = 0;
    int fails = 0;

    int          wd [2] = '{8, 2};
    int          rem [2];
    logic        mdone [2];
    logic [63:0] ms [2], ps [2];
    logic        mc [2], mo [2], pc [2], po [2];

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic void calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub,
                                 output logic [63:0] s, output logic co, output logic ov);
        logic [63:0] m, be;
        logic [64:0] full;
        m    = (64'd1 << w) - 64'd1;
        be   = sub ? (~b & m) : (b & m);
        full = {1'b0, a & m} + {1'b0, be} + {64'd0, cin ^ sub};
        s    = full[63:0] & m;
        co   = full[w];
        ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    task automatic model(input int i, input logic r, input logic st, input logic [63:0] a,
                         input logic [63:0] b, input logic cin, input logic sub);
        if (r) begin
            rem[i] = 0; mdone[i] = 1'b0; ms[i] = '0; mc[i] = 1'b0; mo[i] = 1'b0;
        end else if (rem[i] > 0) begin
            rem[i]--;
            mdone[i] = rem[i] == 0;
            if (rem[i] == 0) begin
                ms[i] = ps[i]; mc[i] = pc[i]; mo[i] = po[i];
            end
        end else begin
            mdone[i] = 1'b0;
            if (st) begin
                rem[i] = wd[i];
                calc(wd[i], a, b, cin, sub, ps[i], pc[i], po[i]);
            end
        end
    endtask

    task automatic step();
        logic r, s8, s2, c8, c2, u8v, u2v;
        logic [63:0] a8, bb8, a2, bb2;
        r = RST;
        s8 = b8.START; a8 = 64'(b8.A); bb8 = 64'(b8.B); c8 = b8.Cin;
        s2 = b2.START; a2 = 64'(b2.A); bb2 = 64'(b2.B); c2 = b2.Cin;
`ifdef SERIAL_ADDER_SUB_EN
        u8v = b8.SUB; u2v = b2.SUB;
`else
        u8v = 1'b0; u2v = 1'b0;
`endif
        @(posedge CLK);
        model(0, r, s8, a8, bb8, c8, u8v);
        model(1, r, s2, a2, bb2, c2, u2v);
        #1;
        chk("w8 outputs", {b8.BUSY, b8.DONE, b8.Cout, b8.OVF, b8.S},
            {rem[0] > 0, mdone[0], mc[0], mo[0], ms[0][7:0]});
        chk("w2 outputs", {b2.BUSY, b2.DONE, b2.Cout, b2.OVF, b2.S},
            {rem[1] > 0, mdone[1], mc[1], mo[1], ms[1][1:0]});
    endtask

    task automatic set8(input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
        b8.START = st; b8.A = a; b8.B = b; b8.Cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        b8.SUB = sub;
`endif
    endtask

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input logic [7:0] es, input logic ec, input logic eo);
        set8(1'b1, a, b, cin, sub);
        step();
        set8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        repeat (8) step();
        chk({nm, " done"}, 64'(b8.DONE), 64'd1);
        chk({nm, " S"}, 64'(b8.S), 64'(es));
        chk({nm, " Cout/OVF"}, {b8.Cout, b8.OVF}, {ec, eo});
        step();
        chk({nm, " hold"}, {b8.DONE, b8.S, b8.Cout, b8.OVF}, {1'b0, es, ec, eo});
    endtask

    initial begin
        int ns;
        logic [3:0] e2;
        set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        b2.START = 1'b0; b2.A = '0; b2.B = '0; b2.Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        b2.SUB = 1'b0;
        ns = 2;
`else
        ns = 1;
`endif
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        repeat (5) step();
        chk("reset idle", {b8.BUSY, b8.DONE, b8.S, b8.Cout, b8.OVF}, 64'd0);

        op8("zero+cin", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        op8("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        set8(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        step();
        set8(1'b0, 8'h10, 8'h20, 1'b0, 1'b0);
        step(); step();
        set8(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step();
        set8(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (5) step();
        chk("ignore start", {b8.DONE, b8.S}, {1'b1, 8'h30});
        set8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        step();
        chk("b2b accept", {b8.BUSY, b8.DONE}, 2'b10);
        set8(1'b0, 8'h55, 8'hAA, 1'b1, 1'b0);
        repeat (8) step();
        chk("b2b result", {b8.DONE, b8.S}, {1'b1, 8'h03});

        set8(1'b1, 8'h21, 8'h11, 1'b0, 1'b0);
        step();
        set8(1'b0, 8'h21, 8'h11, 1'b0, 1'b0);
        repeat (3) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort", {b8.BUSY, b8.DONE, b8.S, b8.Cout, b8.OVF}, 64'd0);
        repeat (8) step();
        chk("abort no done", {b8.BUSY, b8.DONE, b8.S}, 64'd0);
        op8("after abort", 8'h21, 8'h11, 1'b0, 1'b0, 8'h32, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        op8("5-7", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("80-1", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

        for (int u = 0; u < ns; u++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    for (int c = 0; c < 2; c++) begin
                        b2.START = 1'b1; b2.A = 2'(a); b2.B = 2'(b); b2.Cin = 1'(c);
`ifdef SERIAL_ADDER_SUB_EN
                        b2.SUB = 1'(u);
`endif
                        step();
                        b2.START = 1'b0; b2.A = 2'($urandom); b2.B = 2'($urandom);
                        step(); step();
                        e2 = (u == 1) ? 4'(a + (~b & 3) + (1 - c)) : 4'(a + b + c);
                        chk("w2 sweep", {b2.DONE, b2.Cout, b2.S}, {1'b1, e2[2:0]});
                        step();
                    end

        repeat (3000) begin
            RST = $urandom_range(199) == 0;
            set8($urandom_range(2) == 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            b2.START = $urandom_range(2) == 0; b2.A = 2'($urandom); b2.B = 2'($urandom);
            b2.Cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            b2.SUB = 1'($urandom);
`endif
            step();
        end
        RST = 1'b0;
        set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        b2.START = 1'b0;
        repeat (10) step();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised WIDTH-bit bit-serial adder.
- Reuses a single full-adder cell (A/B/Cin → S/Cout) over WIDTH clock cycles, LSB first, with a START/BUSY/DONE handshake.
- Next generation of the team's combinational 1-bit full adder. Adds operand width, sequencing, a registered result and a signed overflow flag.
- Used in area-constrained datapaths where one adder bit-slice is time-shared.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- START  input  1  request; sampled only when the block can accept (IDLE or DONE state).
- A  input  WIDTH  operand A; captured on the accepted START edge.
- B  input  WIDTH  operand B; captured on the accepted START edge.
- Cin  input  1  carry-in; captured on the accepted START edge.
- BUSY  output  1  high while serial addition is in progress.
- DONE  output  1  one-cycle pulse; S/Cout/OVF are valid from this cycle.
- S  output  WIDTH  registered sum; holds last result.
- Cout  output  1  registered carry-out of the MSB.
- OVF  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock CLK. Reset RST is synchronous, active-high, and dominates all other inputs.
- Reset values: state=IDLE, BUSY=0, DONE=0, S=0, Cout=0, OVF=0, bit counter=0, internal shift/carry registers=0.
- States:
  - IDLE: START=1 at edge t0 → capture A, B, Cin into shift registers; counter=0; go to RUN.
  - RUN: each edge computes one bit through the full-adder cell:
    - sum bit = a0^b0^c; c = majority(a0, b0, c).
    - Sum bit is shifted into the MSB of the sum shift register; operand registers shift right.
    - Counter increments each edge.
    - On the edge where counter reaches WIDTH-1, go to DONE and load S, Cout and OVF from the final values.
  - DONE: DONE=1 for exactly one cycle. Then:
    - START=1 → accepted exactly as in IDLE (back-to-back, no bubble), go to RUN.
    - otherwise go to IDLE.
- Latency: START accepted at edge t0 → BUSY=1 after edges t0 .. t0+WIDTH-1 → DONE=1 after edge t0+WIDTH. Throughput is one result per WIDTH cycles.
- BUSY=1 exactly in RUN; DONE=1 exactly in DONE; never both high.
- START while in RUN is ignored. A/B/Cin changes during RUN have no effect.
- S, Cout and OVF update only on the DONE-entry edge. Partial sums are never visible; the previous result is held through IDLE and RUN.
- Width rules:
  - Counter width $clog2(WIDTH).
  - Result is exactly WIDTH bits plus Cout, i.e. {Cout,S} = A+B+Cin modulo 2^(WIDTH+1).
- OVF is the carry into MSB XOR Cout, equivalent to two's-complement signed overflow.
- RST asserted mid-RUN aborts the operation: no DONE pulse, all outputs return to reset values on that edge.
- RST and START high on the same edge: reset wins, START is dropped.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port SUB (input, 1, captured with START).
  - When SUB=1, the captured B is ~B and the captured carry is ~Cin, computing A-B-Cin with Cin as borrow-in.
  - Cout is then the inverted borrow-out (1 = no borrow); OVF is signed subtraction overflow.
  - SUB=0 is identical to addition.
- Undefined: no SUB port; always adds.

Test Plan:
1. Reset: RST=1 for 2 cycles, then release with START=0 → S=0, Cout=0, OVF=0, BUSY=0, DONE=0, held indefinitely.
2. WIDTH=8, A=8'h00, B=8'h00, Cin=1, START pulse at t0 → BUSY high for 8 cycles; DONE after edge t0+8; S=8'h01, Cout=0, OVF=0; values held after DONE drops.
3. A=8'hFF, B=8'h01, Cin=0 → S=8'h00, Cout=1, OVF=0. Then A=8'h7F, B=8'h01, Cin=0 → S=8'h80, Cout=0, OVF=1.
4. Handshake:
   - START with A=8'h10, B=8'h20, then START with A=8'hFF, B=8'hFF at cycle 3 of RUN → ignored; DONE gives S=8'h30.
   - START held during the DONE cycle with A=8'h01, B=8'h02 → accepted with no bubble; next DONE 8 cycles later gives S=8'h03.
5. Abort: RST=1 at the 4th RUN cycle → no DONE; S=0, Cout=0, BUSY=0 next cycle. A fresh START then completes normally.
6. SERIAL_ADDER_SUB_EN defined, SUB=1:
   - A=8'h05, B=8'h07, Cin=0 → S=8'hFE, Cout=0.
   - A=8'h80, B=8'h01, Cin=0 → S=8'h7F, Cout=1, OVF=1.
   - Also run an exhaustive sweep at WIDTH=2 against A+B+Cin.
